// File: rtl/score_controller.sv
// Pong match sequencer: BCD scores, IDLE/SERVE/PLAY/POINT/OVER flow, ball gating and frame-stable digits.
// Optional SCORE_FLASH_EN: text_en blinks in POINT (every 8th tick) and OVER (every 16th tick).
module score_controller #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic [2:0] state,
  output logic       ball_en,
  output logic       text_en,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

  state_t     cur;
  logic [7:0] frame_cnt;
  logic [7:0] work_l;
  logic [7:0] work_r;
  logic       start_q;

  logic       start_edge;
  logic       serve_done;
  logic       point_done;
  logic       win_l;
  logic       win_r;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
  endfunction

  assign state = cur;

  always_comb begin
    start_edge = start_btn & ~start_q;
    serve_done = frame_tick && (frame_cnt == SERVE_LAST);
    point_done = frame_tick && (frame_cnt == POINT_LAST);
    win_l      = (bcd_to_bin(work_l) == WIN_BIN);
    win_r      = (bcd_to_bin(work_r) == WIN_BIN);
  end

  // Display copies sample the working scores only on frame_tick, so a goal on a tick cycle shows one tick later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      frame_cnt <= '0;
      work_l    <= '0;
      work_r    <= '0;
      score_l   <= '0;
      score_r   <= '0;
      start_q   <= 1'b0;
      ball_en   <= 1'b0;
      winner    <= 2'b00;
    end else begin
      start_q <= start_btn;
      if (frame_tick) begin
        score_l <= work_l;
        score_r <= work_r;
      end
      case (cur)
        IDLE: begin
          ball_en <= 1'b0;
          if (start_edge) begin
            cur       <= SERVE;
            frame_cnt <= '0;
          end
        end
        SERVE: begin
          ball_en <= 1'b0;
          if (serve_done) begin
            cur       <= PLAY;
            frame_cnt <= '0;
            ball_en   <= 1'b1;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        PLAY: begin
          // Left wins a simultaneous goal; the right pulse is dropped.
          if (goal_left) begin
            work_l    <= bcd_inc(work_l);
            cur       <= POINT;
            ball_en   <= 1'b0;
            frame_cnt <= '0;
          end else if (goal_right) begin
            work_r    <= bcd_inc(work_r);
            cur       <= POINT;
            ball_en   <= 1'b0;
            frame_cnt <= '0;
          end
        end
        POINT: begin
          ball_en <= 1'b0;
          if (point_done) begin
            frame_cnt <= '0;
            if (win_l) begin
              cur    <= OVER;
              winner <= 2'b01;
            end else if (win_r) begin
              cur    <= OVER;
              winner <= 2'b10;
            end else begin
              cur <= SERVE;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        OVER: begin
          ball_en <= 1'b0;
          if (start_edge) begin
            work_l    <= '0;
            work_r    <= '0;
            winner    <= 2'b00;
            cur       <= SERVE;
            frame_cnt <= '0;
          end
        end
        default: begin
          cur       <= IDLE;
          frame_cnt <= '0;
          ball_en   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_FLASH_EN
  logic       leave;
  logic [3:0] flash_cnt;

  always_comb begin
    leave = 1'b0;
    case (cur)
      IDLE:    leave = start_edge;
      SERVE:   leave = serve_done;
      PLAY:    leave = goal_left | goal_right;
      POINT:   leave = point_done;
      OVER:    leave = start_edge;
      default: leave = 1'b1;
    endcase
  end

  // Every state entry restarts the blink phase with text visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      text_en   <= 1'b0;
      flash_cnt <= '0;
    end else if (leave) begin
      text_en   <= 1'b1;
      flash_cnt <= '0;
    end else if (cur == POINT) begin
      if (frame_tick) begin
        if (flash_cnt[2:0] == 3'd7) begin
          text_en   <= ~text_en;
          flash_cnt <= '0;
        end else begin
          flash_cnt <= flash_cnt + 4'd1;
        end
      end
    end else if (cur == OVER) begin
      if (frame_tick) begin
        if (flash_cnt == 4'd15) begin
          text_en   <= ~text_en;
          flash_cnt <= '0;
        end else begin
          flash_cnt <= flash_cnt + 4'd1;
        end
      end
    end else begin
      text_en <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      text_en <= 1'b0;
    else
      text_en <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_score_controller.sv
// Directed testbench for score_controller with default parameters (WIN_SCORE=11, 120/60 frame phases).
module tb_score_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic       goal_left;
  logic       goal_right;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic [2:0] state;
  logic       ball_en;
  logic       text_en;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;
  int pts_l    = 0;
  int pts_r    = 0;

  score_controller dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .start_btn (start_btn),
    .goal_left (goal_left),
    .goal_right(goal_right),
    .score_l   (score_l),
    .score_r   (score_r),
    .state     (state),
    .ball_en   (ball_en),
    .text_en   (text_en),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic serve_to_play(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == n - 1)
        check_output("serve_wait", 8'(state), 8'd1);
    end
    check_output("serve_done", 8'(state), 8'd2);
    check_output("play_ball", 8'(ball_en), 8'd1);
    check_output("play_text", 8'(text_en), 8'd1);
  endtask

  task automatic point_phase(input logic expect_over);
    logic exp_text;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) begin
        check_output("disp_l", score_l, to_bcd(pts_l));
        check_output("disp_r", score_r, to_bcd(pts_r));
      end
      if (k < 60) begin
`ifdef SCORE_FLASH_EN
        exp_text = ((k / 8) % 2) == 0;
`else
        exp_text = 1'b1;
`endif
        check_output("point_text", 8'(text_en), 8'(exp_text));
      end
      if (k == 59)
        check_output("point_wait", 8'(state), 8'd3);
    end
    check_output("point_exit", 8'(state), expect_over ? 8'd4 : 8'd1);
    check_output("point_exit_ball", 8'(ball_en), 8'd0);
    check_output("point_exit_text", 8'(text_en), 8'd1);
  endtask

  task automatic play_point(input logic left, input logic right, input logic with_tick,
                            input logic expect_over);
    logic [7:0] old_l;
    logic [7:0] old_r;
    old_l      = to_bcd(pts_l);
    old_r      = to_bcd(pts_r);
    goal_left  = left;
    goal_right = right;
    frame_tick = with_tick;
    cycle();
    goal_left  = 1'b0;
    goal_right = 1'b0;
    frame_tick = 1'b0;
    if (left)
      pts_l++;
    else if (right)
      pts_r++;
    check_output("goal_state", 8'(state), 8'd3);
    check_output("goal_ball", 8'(ball_en), 8'd0);
    check_output("goal_hold_l", score_l, old_l);
    check_output("goal_hold_r", score_r, old_r);
    cycle();
    point_phase(expect_over);
    if (!expect_over)
      serve_to_play(120);
  endtask

  initial begin
    rst        = 1'b0;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    goal_left  = 1'b0;
    goal_right = 1'b0;
    cycle();
    cycle();
    check_output("rst_state", 8'(state), 8'd0);
    check_output("rst_score_l", score_l, 8'h00);
    check_output("rst_score_r", score_r, 8'h00);
    check_output("rst_ball", 8'(ball_en), 8'd0);
    check_output("rst_text", 8'(text_en), 8'd0);
    check_output("rst_winner", 8'(winner), 8'd0);

    rst = 1'b1;
    cycle();
    check_output("idle_text", 8'(text_en), 8'd1);
    check_output("idle_state", 8'(state), 8'd0);

    start_btn = 1'b1;
    cycle();
    check_output("start_serve", 8'(state), 8'd1);
    start_btn = 1'b0;
    goal_left = 1'b1;
    cycle();
    goal_left = 1'b0;
    start_btn = 1'b1;
    cycle();
    check_output("serve_start_ignored", 8'(state), 8'd1);
    start_btn = 1'b0;
    cycle();
    serve_to_play(120);
    check_output("serve_goal_ignored", score_l, 8'h00);

    play_point(1'b1, 1'b0, 1'b0, 1'b0);
    play_point(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("dual_goal_r", score_r, 8'h00);
    play_point(1'b1, 1'b0, 1'b1, 1'b0);
    play_point(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 10; i++)
      play_point(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("bcd_carry", score_l, 8'h10);
    check_output("score_r_one", score_r, 8'h01);

    play_point(1'b1, 1'b0, 1'b0, 1'b1);
    check_output("over_state", 8'(state), 8'd4);
    check_output("over_winner", 8'(winner), 8'd1);
    check_output("over_ball", 8'(ball_en), 8'd0);
    goal_left = 1'b1;
    cycle();
    goal_left = 1'b0;
    tick();
    check_output("over_goal_ignored", score_l, 8'h11);
    check_output("over_hold", 8'(state), 8'd4);

    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    pts_l = 0;
    pts_r = 0;
    check_output("restart_state", 8'(state), 8'd1);
    check_output("restart_winner", 8'(winner), 8'd0);
    check_output("restart_disp_hold", score_l, 8'h11);
    tick();
    check_output("restart_clear_l", score_l, 8'h00);
    check_output("restart_clear_r", score_r, 8'h00);
    serve_to_play(119);

    play_point(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("pre_reset_l", score_l, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_state", 8'(state), 8'd0);
    check_output("async_score_l", score_l, 8'h00);
    check_output("async_score_r", score_r, 8'h00);
    check_output("async_ball", 8'(ball_en), 8'd0);
    check_output("async_text", 8'(text_en), 8'd0);
    check_output("async_winner", 8'(winner), 8'd0);
    cycle();
    rst = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
